// File: rtl/rv32i_rf_pkg.sv
// Shared definitions for the RV32I/RV32E register file with accelerator mailbox.
//   mbox_state_e : mailbox controller state
//   DEF_*        : default mailbox register placement (RV32I, 32 registers)
package rv32i_rf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mbox_state_e;

  localparam int DEF_IN_BASE    = 28;
  localparam int DEF_N_IN       = 2;
  localparam int DEF_START_REG  = 31;
  localparam int DEF_RESULT_REG = 10;

endpackage

// File: rtl/rv32i_mbox_ctrl.sv
// Mailbox controller: IDLE/RUN/DONE FSM, operand latches, result register
// and host handshake outputs.
//   req_valid/req_ready/req_opnd : host job offer; operands latched on accept
//   res_valid/res_ready/res_data : result handshake, res_data held while DONE
//   result_we, abort_we, wdata   : decoded core writes from the register file
//   run, opnd                    : exported to the register-file read mux
module rv32i_mbox_ctrl
  import rv32i_rf_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int N_IN = DEF_N_IN
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [N_IN*XLEN-1:0]       req_opnd,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [XLEN-1:0]            res_data,
  output logic                       busy,
  input  logic                       result_we,
  input  logic                       abort_we,
  input  logic [XLEN-1:0]            wdata,
  output logic                       run,
  output logic [N_IN-1:0][XLEN-1:0]  opnd
);

  mbox_state_e                state_q, state_d;
  logic [N_IN-1:0][XLEN-1:0]  opnd_q, opnd_d;
  logic [XLEN-1:0]            res_data_q, res_data_d;

  always_comb begin
    state_d    = state_q;
    opnd_d     = opnd_q;
    res_data_d = res_data_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          opnd_d  = req_opnd;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Single write port: result_we and abort_we are mutually exclusive.
        if (result_we) begin
          res_data_d = wdata;
          state_d    = ST_DONE;
        end else if (abort_we) begin
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        // Return to IDLE first; a pending job is taken on the following edge.
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      opnd_q     <= '0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      opnd_q     <= opnd_d;
      res_data_q <= res_data_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign res_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign run       = (state_q == ST_RUN);
  assign res_data  = res_data_q;
  assign opnd      = opnd_q;

endmodule

// File: rtl/rv32i_mbox_reg_file.sv
// RV32I/RV32E integer register file with an accelerator mailbox mapped onto
// architectural registers: operand registers (read-only, latched per job),
// a start/status register and a result register that completes the job.
//   rs1/rs2 : combinational read ports
//   rd_*    : single write port, commits at the rising edge
//   req_* / res_* / busy : host job handshake (see rv32i_mbox_ctrl)
// Optional macro RF_BYPASS_EN: forward rd_data to a same-cycle read of a
// writable (non-mailbox-operand, non-start) register.
module rv32i_mbox_reg_file
  import rv32i_rf_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NREGS      = 32,
  parameter int IN_BASE    = DEF_IN_BASE,
  parameter int N_IN       = DEF_N_IN,
  parameter int START_REG  = DEF_START_REG,
  parameter int RESULT_REG = DEF_RESULT_REG
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [$clog2(NREGS)-1:0]   rs1_addr,
  input  logic [$clog2(NREGS)-1:0]   rs2_addr,
  output logic [XLEN-1:0]            rs1_data,
  output logic [XLEN-1:0]            rs2_data,
  input  logic                       rd_we,
  input  logic [$clog2(NREGS)-1:0]   rd_addr,
  input  logic [XLEN-1:0]            rd_data,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [N_IN*XLEN-1:0]       req_opnd,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [XLEN-1:0]            res_data,
  output logic                       busy
);

  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] START_A  = AW'(START_REG);
  localparam logic [AW-1:0] RESULT_A = AW'(RESULT_REG);

  if (IN_BASE < 1 || N_IN < 1 || IN_BASE + N_IN > NREGS ||
      START_REG < 1 || START_REG >= NREGS ||
      RESULT_REG < 1 || RESULT_REG >= NREGS || START_REG == RESULT_REG ||
      (START_REG  >= IN_BASE && START_REG  < IN_BASE + N_IN) ||
      (RESULT_REG >= IN_BASE && RESULT_REG < IN_BASE + N_IN)) begin : g_param_err
    $error("rv32i_mbox_reg_file: illegal mailbox register placement");
  end

  function automatic logic is_opnd(input logic [AW-1:0] a);
    return (int'(a) >= IN_BASE) && (int'(a) < IN_BASE + N_IN);
  endfunction

  // Writable means it has real storage: not x0, operands or start/status.
  function automatic logic is_writable(input logic [AW-1:0] a);
    return (a != '0) && !is_opnd(a) && (a != START_A);
  endfunction

  logic                       run;
  logic [N_IN-1:0][XLEN-1:0]  opnd;
  logic                       result_we, abort_we;

  assign result_we = rd_we && (rd_addr == RESULT_A);
  assign abort_we  = rd_we && (rd_addr == START_A) && !rd_data[0];

  rv32i_mbox_ctrl #(.XLEN(XLEN), .N_IN(N_IN)) u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_opnd  (req_opnd),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy),
    .result_we (result_we),
    .abort_we  (abort_we),
    .wdata     (rd_data),
    .run       (run),
    .opnd      (opnd)
  );

  // Storage entries for x0, operands and start stay at reset value; the read
  // mux never selects them.
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (rd_we && is_writable(rd_addr)) regs_d[rd_addr] = rd_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  logic [1:0][AW-1:0]   rs_addr;
  logic [1:0][XLEN-1:0] rs_data;

  assign rs_addr = {rs2_addr, rs1_addr};

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [XLEN-1:0] rd_val;
    always_comb begin
      rd_val = regs_q[rs_addr[p]];
`ifdef RF_BYPASS_EN
      if (rd_we && (rd_addr == rs_addr[p]) && is_writable(rd_addr)) rd_val = rd_data;
`endif
      // Mailbox registers override storage and are never forwarded.
      for (int k = 0; k < N_IN; k++) begin
        if (int'(rs_addr[p]) == IN_BASE + k) rd_val = opnd[k];
      end
      if (rs_addr[p] == START_A) rd_val = {{(XLEN-1){1'b0}}, run};
      if (rs_addr[p] == '0)      rd_val = '0;
    end
    assign rs_data[p] = rd_val;
  end

  assign rs1_data = rs_data[0];
  assign rs2_data = rs_data[1];

endmodule

// File: tb/tb_rv32i_mbox_reg_file.sv
module tb_rv32i_mbox_reg_file;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  // RV32I instance
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] rs1_data, rs2_data, rd_data, res_data;
  logic        rd_we, req_valid, req_ready, res_valid, res_ready, busy;
  logic [63:0] req_opnd;
  // RV32E instance (operands x12/x13, start x15, result x10)
  logic [3:0]  e_rs1_addr, e_rs2_addr, e_rd_addr;
  logic [31:0] e_rs1_data, e_rs2_data, e_rd_data, e_res_data;
  logic        e_rd_we, e_req_valid, e_req_ready, e_res_valid, e_res_ready, e_busy;
  logic [63:0] e_req_opnd;

  rv32i_mbox_reg_file u_dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_opnd(req_opnd),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
  );

  rv32i_mbox_reg_file #(.NREGS(16), .IN_BASE(12), .N_IN(2), .START_REG(15), .RESULT_REG(10)) u_dut_e (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(e_rs1_addr), .rs2_addr(e_rs2_addr), .rs1_data(e_rs1_data), .rs2_data(e_rs2_data),
    .rd_we(e_rd_we), .rd_addr(e_rd_addr), .rd_data(e_rd_data),
    .req_valid(e_req_valid), .req_ready(e_req_ready), .req_opnd(e_req_opnd),
    .res_valid(e_res_valid), .res_ready(e_res_ready), .res_data(e_res_data), .busy(e_busy)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic start_job(input logic [31:0] op1, input logic [31:0] op0);
    req_opnd = {op1, op0}; req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rd_we = 1'b0; rd_addr = '0; rd_data = '0; req_valid = 1'b0;
    res_ready = 1'b0; req_opnd = '0; rs1_addr = '0; rs2_addr = '0;
    e_rd_we = 1'b0; e_rd_addr = '0; e_rd_data = '0; e_req_valid = 1'b0;
    e_res_ready = 1'b0; e_req_opnd = '0; e_rs1_addr = '0; e_rs2_addr = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick;
    n_vec++;
    if (req_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0 || res_data !== 32'h0) begin
      n_err++;
      $display("FAIL reset_ctrl got rdy=%b vld=%b busy=%b res=%h want 1 0 0 0",
               req_ready, res_valid, busy, res_data);
    end
    for (int a = 0; a < 32; a++) begin
      rs1_addr = 5'(a); rs2_addr = 5'(31 - a); e_rs1_addr = 4'(a % 16);
      exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      @(negedge clk);
      exp = exp_q.pop_front(); n_vec++;
      if (rs1_data !== exp) begin n_err++; $display("FAIL reset_x%0d got %h want %h", a, rs1_data, exp); end
      exp = exp_q.pop_front(); n_vec++;
      if (rs2_data !== exp) begin n_err++; $display("FAIL reset_x%0d got %h want %h", 31 - a, rs2_data, exp); end
      exp = exp_q.pop_front(); n_vec++;
      if (e_rs1_data !== exp) begin n_err++; $display("FAIL reset_e_x%0d got %h want %h", a % 16, e_rs1_data, exp); end
      tick;
    end
  endtask

  task automatic test_full_job;
    logic [4:0]  addrs [3] = '{5'd28, 5'd29, 5'd31};
    logic [31:0] vals  [3] = '{32'd48, 32'd18, 32'd1};
    start_job(32'd18, 32'd48);
    n_vec++;
    if (busy !== 1'b1 || req_ready !== 1'b0) begin
      n_err++; $display("FAIL job_accept got busy=%b rdy=%b want 1 0", busy, req_ready);
    end
    for (int i = 0; i < 3; i++) begin
      rs1_addr = addrs[i]; exp_q.push_back(vals[i]);
      @(negedge clk);
      exp = exp_q.pop_front(); n_vec++;
      if (rs1_data !== exp) begin n_err++; $display("FAIL job_x%0d got %h want %h", addrs[i], rs1_data, exp); end
      tick;
    end
    rd_we = 1'b1; rd_addr = 5'd10; rd_data = 32'd6;
    tick;
    rd_we = 1'b0;
    n_vec++;
    if (res_valid !== 1'b1 || res_data !== 32'd6 || req_ready !== 1'b0) begin
      n_err++; $display("FAIL job_done got vld=%b res=%h rdy=%b want 1 00000006 0", res_valid, res_data, req_ready);
    end
    rs1_addr = 5'd10; rs2_addr = 5'd31; exp_q.push_back(32'd6); exp_q.push_back(32'd0);
    @(negedge clk);
    exp = exp_q.pop_front(); n_vec++;
    if (rs1_data !== exp) begin n_err++; $display("FAIL done_x10 got %h want %h", rs1_data, exp); end
    exp = exp_q.pop_front(); n_vec++;
    if (rs2_data !== exp) begin n_err++; $display("FAIL done_x31 got %h want %h", rs2_data, exp); end
    tick;
    res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
    n_vec++;
    if (req_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL res_hs got rdy=%b vld=%b busy=%b want 1 0 0", req_ready, res_valid, busy);
    end
    // Result write outside RUN updates x10 only.
    rd_we = 1'b1; rd_addr = 5'd10; rd_data = 32'd7;
    tick;
    rd_we = 1'b0; rs1_addr = 5'd10; exp_q.push_back(32'd7);
    @(negedge clk);
    exp = exp_q.pop_front(); n_vec++;
    if (rs1_data !== exp || res_data !== 32'd6 || res_valid !== 1'b0) begin
      n_err++; $display("FAIL idle_result got x10=%h res=%h vld=%b want %h 00000006 0", rs1_data, res_data, res_valid, exp);
    end
    tick;
  endtask

  task automatic test_protection;
    start_job(32'd18, 32'd48);
    rd_we = 1'b1; rd_addr = 5'd28; rd_data = 32'hDEAD;
    tick;
    rd_addr = 5'd0; rd_data = 32'd5;
    tick;
    rd_we = 1'b0; rs1_addr = 5'd28; rs2_addr = 5'd0;
    exp_q.push_back(32'd48); exp_q.push_back(32'd0);
    @(negedge clk);
    exp = exp_q.pop_front(); n_vec++;
    if (rs1_data !== exp) begin n_err++; $display("FAIL prot_x28 got %h want %h", rs1_data, exp); end
    exp = exp_q.pop_front(); n_vec++;
    if (rs2_data !== exp) begin n_err++; $display("FAIL prot_x0 got %h want %h", rs2_data, exp); end
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL prot_busy got %b want 1", busy); end
    tick;
    rd_we = 1'b1; rd_addr = 5'd31; rd_data = 32'd0;
    tick;
    rd_we = 1'b0;
  endtask

  task automatic test_abort;
    start_job(32'd1, 32'd2);
    rd_we = 1'b1; rd_addr = 5'd31; rd_data = 32'd1;
    tick;
    n_vec++;
    if (busy !== 1'b1 || res_valid !== 1'b0) begin
      n_err++; $display("FAIL start_w1 got busy=%b vld=%b want 1 0", busy, res_valid);
    end
    rd_data = 32'd0;
    tick;
    rd_we = 1'b0;
    for (int c = 0; c < 2; c++) begin
      n_vec++;
      if (busy !== 1'b0 || req_ready !== 1'b1 || res_valid !== 1'b0) begin
        n_err++; $display("FAIL abort_c%0d got busy=%b rdy=%b vld=%b want 0 1 0", c, busy, req_ready, res_valid);
      end
      tick;
    end
    start_job(32'd3, 32'd4);
    rs1_addr = 5'd28; rs2_addr = 5'd29; exp_q.push_back(32'd4); exp_q.push_back(32'd3);
    @(negedge clk);
    exp = exp_q.pop_front(); n_vec++;
    if (rs1_data !== exp || busy !== 1'b1) begin n_err++; $display("FAIL reaccept_x28 got %h busy=%b want %h 1", rs1_data, busy, exp); end
    exp = exp_q.pop_front(); n_vec++;
    if (rs2_data !== exp) begin n_err++; $display("FAIL reaccept_x29 got %h want %h", rs2_data, exp); end
    tick;
    rd_we = 1'b1; rd_addr = 5'd31; rd_data = 32'd0;
    tick;
    rd_we = 1'b0;
  endtask

  task automatic test_back_to_back;
    start_job(32'd11, 32'd22);
    rd_we = 1'b1; rd_addr = 5'd10; rd_data = 32'h55;
    tick;
    rd_we = 1'b0; req_opnd = {32'd33, 32'd44}; req_valid = 1'b1;
    tick;
    n_vec++;
    if (req_ready !== 1'b0 || res_valid !== 1'b1) begin
      n_err++; $display("FAIL b2b_stall got rdy=%b vld=%b want 0 1", req_ready, res_valid);
    end
    res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
    rs1_addr = 5'd28; exp_q.push_back(32'd22);
    @(negedge clk);
    exp = exp_q.pop_front(); n_vec++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || rs1_data !== exp) begin
      n_err++; $display("FAIL b2b_gap got rdy=%b busy=%b x28=%h want 1 0 %h", req_ready, busy, rs1_data, exp);
    end
    tick;
    req_valid = 1'b0;
    rs1_addr = 5'd28; rs2_addr = 5'd29; exp_q.push_back(32'd44); exp_q.push_back(32'd33);
    @(negedge clk);
    exp = exp_q.pop_front(); n_vec++;
    if (rs1_data !== exp || busy !== 1'b1) begin n_err++; $display("FAIL b2b_x28 got %h busy=%b want %h 1", rs1_data, busy, exp); end
    exp = exp_q.pop_front(); n_vec++;
    if (rs2_data !== exp) begin n_err++; $display("FAIL b2b_x29 got %h want %h", rs2_data, exp); end
    tick;
    rd_we = 1'b1; rd_addr = 5'd31; rd_data = 32'd0;
    tick;
    rd_we = 1'b0;
  endtask

  task automatic test_bypass;
    logic byp;
`ifdef RF_BYPASS_EN
    byp = 1'b1;
`else
    byp = 1'b0;
`endif
    rd_we = 1'b1; rd_addr = 5'd5; rd_data = 32'h1111;
    e_rd_we = 1'b1; e_rd_addr = 4'd5; e_rd_data = 32'h1111;
    tick;
    rd_data = 32'h1234; rs1_addr = 5'd5; e_rd_data = 32'h1234; e_rs1_addr = 4'd5;
    exp_q.push_back(byp ? 32'h1234 : 32'h1111); exp_q.push_back(byp ? 32'h1234 : 32'h1111);
    @(negedge clk);
    exp = exp_q.pop_front(); n_vec++;
    if (rs1_data !== exp) begin n_err++; $display("FAIL byp_x5 got %h want %h", rs1_data, exp); end
    exp = exp_q.pop_front(); n_vec++;
    if (e_rs1_data !== exp) begin n_err++; $display("FAIL byp_e_x5 got %h want %h", e_rs1_data, exp); end
    tick;
    e_rd_we = 1'b0;
    // Result register forwards; operand and start registers never do.
    rd_addr = 5'd10; rd_data = 32'hABC; rs1_addr = 5'd10;
    exp_q.push_back(32'h1234); exp_q.push_back(byp ? 32'hABC : 32'h55);
    @(negedge clk);
    exp = exp_q.pop_front(); n_vec++;
    if (e_rs1_data !== exp) begin n_err++; $display("FAIL byp_e_commit got %h want %h", e_rs1_data, exp); end
    exp = exp_q.pop_front(); n_vec++;
    if (rs1_data !== exp) begin n_err++; $display("FAIL byp_x10 got %h want %h", rs1_data, exp); end
    tick;
    rd_addr = 5'd28; rd_data = 32'hDEAD; rs1_addr = 5'd28; exp_q.push_back(32'd44);
    @(negedge clk);
    exp = exp_q.pop_front(); n_vec++;
    if (rs1_data !== exp) begin n_err++; $display("FAIL byp_x28 got %h want %h", rs1_data, exp); end
    tick;
    rd_addr = 5'd31; rd_data = 32'd1; rs1_addr = 5'd31; exp_q.push_back(32'd0);
    @(negedge clk);
    exp = exp_q.pop_front(); n_vec++;
    if (rs1_data !== exp || busy !== 1'b0) begin n_err++; $display("FAIL byp_x31 got %h busy=%b want %h 0", rs1_data, busy, exp); end
    tick;
    rd_we = 1'b0; e_rd_we = 1'b1; e_rd_addr = 4'd12; e_rd_data = 32'h77; e_rs1_addr = 4'd12;
    exp_q.push_back(32'h0);
    @(negedge clk);
    exp = exp_q.pop_front(); n_vec++;
    if (e_rs1_data !== exp) begin n_err++; $display("FAIL byp_e_x12 got %h want %h", e_rs1_data, exp); end
    tick;
    e_rd_we = 1'b0;
  endtask

  task automatic test_reset_mid_job;
    start_job(32'd9, 32'd9);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_err++; $display("FAIL rst_mid got busy=%b vld=%b rdy=%b want 0 0 1", busy, res_valid, req_ready);
    end
    tick;
    rst_n = 1'b1;
    rs1_addr = 5'd28; rs2_addr = 5'd5; exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    @(negedge clk);
    exp = exp_q.pop_front(); n_vec++;
    if (rs1_data !== exp) begin n_err++; $display("FAIL rst_mid_x28 got %h want %h", rs1_data, exp); end
    exp = exp_q.pop_front(); n_vec++;
    if (rs2_data !== exp) begin n_err++; $display("FAIL rst_mid_x5 got %h want %h", rs2_data, exp); end
    tick;
  endtask

  initial begin
    test_reset;
    test_full_job;
    test_protection;
    test_abort;
    test_back_to_back;
    test_bypass;
    test_reset_mid_job;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
